sand_sweep_ctrl: RTL
====================

// Module: sand_sweep_ctrl
// PURPOSE
//  Initiator side of the per-cell update handshake. Sweeps every cell that can fall, one per handshake.
//  Order: bottom-to-top, skipping the bottom row. Drives ready/base-address to one cell-update engine.
//  Waits for its done (or a watchdog expiry). Sits between the frame tick and the cell engine.
// PARAMETERS
//  ACTIVE_COLUMNS   640                                   pixels per row (>=2)
//  ACTIVE_ROWS      480                                   rows per frame (>=2)
//  ADDR_WIDTH       $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS)    framebuffer address width
//  WATCHDOG_CYCLES  8                                     max WAIT cycles before forced advance (>=2)
// PORTS
//  clk_i                input   1           clock; all logic on posedge
//  reset_ni             input   1           asynchronous, active-low reset
//  start_i              input   1           frame tick; one-cycle pulse requests a sweep
//  cell_done_i          input   1           engine finished current cell
//  cell_ready_o         output  1           one-cycle pulse: engine may start on cell_base_address_o
//  cell_base_address_o  output  ADDR_WIDTH  cell under update; stable from ISSUE through WAIT
//  busy_o               output  1           high in any state except IDLE
//  frame_done_o         output  1           one-cycle pulse after the last cell of a sweep
//  timeout_count_o      output  16          saturating count of watchdog expiries since reset
// BEHAVIOUR
//  Reset (reset_ni=0, async): state=IDLE, all outputs 0, pending=0, scan dir=L->R, counters 0.
//  FSM (registered state; outputs decoded from state):
//   IDLE   start_i=1 or pending=1 -> ISSUE. Load addr=(ACTIVE_ROWS-2)*ACTIVE_COLUMNS + first col. Clear pending.
//   ISSUE  cell_ready_o=1 for exactly one cycle -> WAIT. Clear watchdog counter.
//   WAIT   cell_done_i=1 -> ADVANCE. Else wdog++.
//          wdog reaches WATCHDOG_CYCLES-1 with no done -> ADVANCE; timeout_count_o++ (saturates 16'hFFFF).
//   ADVANCE  last cell (row 0, last col) -> FDONE. Else step addr and col -> ISSUE.
//   FDONE  frame_done_o=1 for one cycle -> IDLE. Toggle scan dir (ALT_SCAN_EN only).
//  cell_done_i is sampled only in WAIT; ignored in all other states.
//  Done in the first WAIT cycle is legal. Minimum 3 cycles per cell.
//  Addressing: col counter 0..ACTIVE_COLUMNS-1; addr arithmetic is modulo 2^ADDR_WIDTH.
//   L->R: first col 0. Mid-row addr+1. Row end (col=COLS-1): addr - 2*ACTIVE_COLUMNS + 1.
//   R->L: first col COLS-1. Always addr-1, including across rows.
//  Bottom row never issued: its down-neighbour is out of range.
//  Row 0 cell at col 0 (L->R last = row0 col COLS-1) terminates the sweep.
//  start_i while busy_o=1: pending set (one deep; further starts lost).
//   The pending sweep begins in the cycle after FDONE.
//  start_i in the FDONE cycle: also pending, same rule.
//  Reset mid-sweep: immediate IDLE. No frame_done_o. Pending cleared.
// CONFIGURATION
//  SAND_ALT_SCAN_EN defined:
//   Column direction alternates every completed frame: L->R, R->L, L->R, ...
//   Removes the left-drift bias of the cell rules.
//  Undefined: every frame scans L->R; dir register is absent.
// TESTING (ACTIVE_COLUMNS=4, ACTIVE_ROWS=3, WATCHDOG_CYCLES=4 unless noted)
//  1 Pulse start_i, engine returns done 1 cycle after each ready.
//    Addrs 4,5,6,7,0,1,2,3. 8 ready pulses. frame_done_o once. busy_o low after.
//  2 SAND_ALT_SCAN_EN: two frames -> frame1 4,5,6,7,0,1,2,3; frame2 7,6,5,4,3,2,1,0.
//    Without macro, frame2 repeats frame1.
//  3 Engine never asserts done.
//    Each cell held 4 WAIT cycles. Sweep still completes. timeout_count_o=8.
//  4 start_i pulsed during cell 6 of frame 1.
//    Frame 2's first ready comes 2 cycles after frame_done_o. No third frame.
//  5 reset_ni low while WAIT on addr 1.
//    All outputs 0 at once. No frame_done_o. Next start_i restarts at addr 4.
//  6 cell_done_i held high through IDLE/ISSUE.
//    No cell skipped; each addr gets exactly one ready.

Source files
------------

// File: rtl/sand_sweep_ctrl.sv
// Sand sweep initiator: one ready/done handshake per fallable cell, bottom-up.
// Define SAND_ALT_SCAN_EN to alternate column direction on every frame.
module sand_sweep_ctrl #(
  parameter int ACTIVE_COLUMNS  = 640,
  parameter int ACTIVE_ROWS     = 480,
  parameter int ADDR_WIDTH      = $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS),
  parameter int WATCHDOG_CYCLES = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  start_i,
  input  logic                  cell_done_i,
  output logic                  cell_ready_o,
  output logic [ADDR_WIDTH-1:0] cell_base_address_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic [15:0]           timeout_count_o
);

  localparam int CW = $clog2(ACTIVE_COLUMNS);
  localparam int RW = $clog2(ACTIVE_ROWS);
  localparam int WW = $clog2(WATCHDOG_CYCLES);

  localparam logic [CW-1:0] LAST_COL = CW'(ACTIVE_COLUMNS-1);
  localparam logic [RW-1:0] FIRST_ROW = RW'(ACTIVE_ROWS-2);
  localparam logic [WW-1:0] WD_LAST = WW'(WATCHDOG_CYCLES-1);

  localparam logic [ADDR_WIDTH-1:0] START_LR =
    ADDR_WIDTH'((ACTIVE_ROWS-2)*ACTIVE_COLUMNS);
  localparam logic [ADDR_WIDTH-1:0] START_RL =
    ADDR_WIDTH'((ACTIVE_ROWS-1)*ACTIVE_COLUMNS-1);
  localparam logic [ADDR_WIDTH-1:0] ROW_BACK =
    ADDR_WIDTH'(2*ACTIVE_COLUMNS-1);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ADVANCE,
    FDONE
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [CW-1:0]           col_q;
  logic [RW-1:0]           row_q;
  logic [WW-1:0]           wdog_q;
  logic                    pending_q;
  logic                    scan_rl;
  logic                    last_cell;

`ifdef SAND_ALT_SCAN_EN
  logic dir_q;
  assign scan_rl = dir_q;
`else
  assign scan_rl = 1'b0;
`endif

  // Sweep ends on row 0 at the column the current direction reaches last.
  assign last_cell = (row_q == '0) &&
                     (col_q == (scan_rl ? '0 : LAST_COL));

  assign cell_base_address_o = addr_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      col_q           <= '0;
      row_q           <= '0;
      wdog_q          <= '0;
      pending_q       <= 1'b0;
      cell_ready_o    <= 1'b0;
      busy_o          <= 1'b0;
      frame_done_o    <= 1'b0;
      timeout_count_o <= '0;
`ifdef SAND_ALT_SCAN_EN
      dir_q           <= 1'b0;
`endif
    end else begin
      cell_ready_o <= 1'b0;
      frame_done_o <= 1'b0;
      if (state_q != IDLE && start_i) begin
        pending_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (start_i || pending_q) begin
            state_q      <= ISSUE;
            cell_ready_o <= 1'b1;
            busy_o       <= 1'b1;
            pending_q    <= 1'b0;
            row_q        <= FIRST_ROW;
            col_q        <= scan_rl ? LAST_COL : '0;
            addr_q       <= scan_rl ? START_RL : START_LR;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          wdog_q  <= '0;
        end
        WAIT: begin
          if (cell_done_i) begin
            state_q <= ADVANCE;
          end else if (wdog_q == WD_LAST) begin
            state_q <= ADVANCE;
            if (timeout_count_o != 16'hFFFF) begin
              timeout_count_o <= timeout_count_o + 16'd1;
            end
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        ADVANCE: begin
          if (last_cell) begin
            state_q      <= FDONE;
            frame_done_o <= 1'b1;
          end else begin
            state_q      <= ISSUE;
            cell_ready_o <= 1'b1;
            if (scan_rl) begin
              addr_q <= addr_q - ONE;
              if (col_q == '0) begin
                col_q <= LAST_COL;
                row_q <= row_q - 1'b1;
              end else begin
                col_q <= col_q - 1'b1;
              end
            end else if (col_q == LAST_COL) begin
              // Jump back to column 0 of the row above.
              addr_q <= addr_q - ROW_BACK;
              col_q  <= '0;
              row_q  <= row_q - 1'b1;
            end else begin
              addr_q <= addr_q + ONE;
              col_q  <= col_q + 1'b1;
            end
          end
        end
        FDONE: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
`ifdef SAND_ALT_SCAN_EN
          dir_q   <= ~dir_q;
`endif
        end
        default: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
